// File: rtl/turn_signal_scheduler.sv
// rtl/turn_signal_scheduler.sv - fixed-priority indicator lamp sequencer with shared blink phase.
// Optional lane-change tap latch enabled by defining TURN_LANE_CHANGE_EN.
module turn_signal_scheduler #(
  parameter int PERIOD      = 10_000_000,
  parameter int HALF        = 5_000_000,
  parameter int TAP_FLASHES = 3,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_btn,
  input  logic       brake,
  output logic [1:0] led,
  output logic [2:0] state,
  output logic       flash_tick
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_IDLE   = 3'd1,
    S_LEFT   = 3'd2,
    S_RIGHT  = 3'd3,
    S_HAZARD = 3'd4
  } st_e;

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);
  localparam logic [3:0]       TAP_C  = 4'(TAP_FLASHES);

  st_e              state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             hazard_q, hazard_d;
  logic             btn_q;
  logic [1:0]       led_q, led_d;
  logic             tick_q, tick_d;
  logic             blink;
  logic             on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      hazard_q <= 1'b0;
      btn_q    <= 1'b0;
      led_q    <= 2'b00;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      hazard_q <= hazard_d;
      btn_q    <= hazard_btn;
      led_q    <= led_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    hazard_d = hazard_q;
    state_d  = S_IDLE;
    cnt_d    = '0;
    fcnt_d   = '0;
    tick_d   = 1'b0;
    led_d    = 2'b00;

    // The latch toggles on the same edge that samples the button, so state sees it immediately.
    if (!power)
      hazard_d = 1'b0;
    else if (hazard_btn && !btn_q)
      hazard_d = ~hazard_q;

    if (!power)                      state_d = S_OFF;
    else if (hazard_d)               state_d = S_HAZARD;
    else if (left_req && right_req)  state_d = S_IDLE;
    else if (left_req)               state_d = S_LEFT;
    else if (right_req)              state_d = S_RIGHT;
    else                             state_d = S_IDLE;

`ifdef TURN_LANE_CHANGE_EN
    if (power && !hazard_d && !left_req && !right_req &&
        (state_q == S_LEFT || state_q == S_RIGHT) && fcnt_q < TAP_C)
      state_d = state_q;
`endif

    blink = (state_d == S_LEFT) || (state_d == S_RIGHT) || (state_d == S_HAZARD);

    // Any state change restarts the phase so a new pattern opens with a full on-phase.
    if (blink && state_d == state_q) begin
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      fcnt_d = fcnt_q;
      if (cnt_d == LAST) begin
        tick_d = 1'b1;
        if (fcnt_q != 4'hF)
          fcnt_d = fcnt_q + 4'd1;
      end
    end

    on = blink && (cnt_d < HALF_C);

    case (state_d)
      S_IDLE:   led_d = {brake, brake};
      S_LEFT:   led_d = {on, brake};
      S_RIGHT:  led_d = {brake, on};
      S_HAZARD: led_d = {on, on};
      default:  led_d = 2'b00;
    endcase
  end

  assign led        = led_q;
  assign state      = state_q;
  assign flash_tick = tick_q;

endmodule

// File: tb/tb_turn_signal_scheduler.sv
// tb/tb_turn_signal_scheduler.sv - scoreboard bench for turn_signal_scheduler (PERIOD=10, HALF=5, TAP=3).
module tb_turn_signal_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       power = 1'b0;
  logic       left_req = 1'b0;
  logic       right_req = 1'b0;
  logic       hazard_btn = 1'b0;
  logic       brake = 1'b0;
  logic [1:0] led;
  logic [2:0] state;
  logic       flash_tick;

  typedef struct {
    logic [2:0] st;
    logic [1:0] led;
    logic       tick;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   tag = 0;

  turn_signal_scheduler #(
    .PERIOD(10), .HALF(5), .TAP_FLASHES(3), .CNT_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .power(power), .left_req(left_req),
    .right_req(right_req), .hazard_btn(hazard_btn), .brake(brake),
    .led(led), .state(state), .flash_tick(flash_tick)
  );

  always #5 clk = ~clk;

  task automatic check_one();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || led !== e.led || flash_tick !== e.tick) begin
        failures++;
        $display("FAIL chk%0d: got state=%0d led=%b tick=%b, required state=%0d led=%b tick=%b",
                 e.tag, state, led, flash_tick, e.st, e.led, e.tick);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    check_one();
  end

  always @(negedge rst_n) begin
    #1;
    check_one();
  end

  task automatic expect_out(input logic [2:0] st, input logic [1:0] ld, input logic tk);
    exp_t e;
    tag++;
    e.st = st; e.led = ld; e.tick = tk; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic p, input logic l, input logic r, input logic h, input logic b,
                      input logic [2:0] st, input logic [1:0] ld, input logic tk);
    power = p; left_req = l; right_req = r; hazard_btn = h; brake = b;
    expect_out(st, ld, tk);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #2;
    // held in reset: outputs stay at reset values
    step(1, 1, 0, 0, 0, 3'd0, 2'b00, 1'b0);
    rst_n = 1'b1;

    // left held 30 cycles: 5 on / 5 off x3, tick at 10/20/30
    for (int i = 0; i < 30; i++)
      step(1, 1, 0, 0, 0, 3'd2, {(i % 10) < 5, 1'b0}, (i % 10) == 9);
    // brake steady on right side, left keeps phase
    for (int i = 0; i < 10; i++)
      step(1, 1, 0, 0, 1, 3'd2, {i < 5, 1'b1}, i == 9);
    step(1, 0, 0, 0, 1, 3'd1, 2'b11, 1'b0);
    step(1, 0, 0, 0, 0, 3'd1, 2'b00, 1'b0);

    // left to counter 7, then switch right: full on-phase from 0
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, 0, 0, 3'd2, {i < 5, 1'b0}, 1'b0);
    for (int i = 0; i < 10; i++)
      step(1, 0, 1, 0, 0, 3'd3, {1'b0, i < 5}, i == 9);

    // hazard: held button toggles once, brake ignored
    step(1, 0, 1, 1, 0, 3'd4, 2'b11, 1'b0);
    for (int i = 1; i < 4; i++)
      step(1, 0, 1, 1, 1, 3'd4, 2'b11, 1'b0);
    step(1, 0, 1, 0, 1, 3'd4, 2'b11, 1'b0);
    for (int i = 5; i < 10; i++)
      step(1, 0, 1, 0, 0, 3'd4, 2'b00, i == 9);
    step(1, 0, 1, 1, 0, 3'd3, 2'b01, 1'b0);
    step(1, 0, 1, 0, 1, 3'd3, 2'b11, 1'b0);
    step(1, 0, 1, 1, 0, 3'd4, 2'b11, 1'b0);
    step(0, 0, 1, 0, 0, 3'd0, 2'b00, 1'b0);
    step(0, 0, 1, 1, 0, 3'd0, 2'b00, 1'b0);
    step(1, 0, 1, 1, 0, 3'd3, 2'b01, 1'b0);
    step(1, 1, 1, 0, 1, 3'd1, 2'b11, 1'b0);

    // asynchronous reset during on-phase
    step(1, 1, 0, 0, 0, 3'd2, 2'b10, 1'b0);
    step(1, 1, 0, 0, 0, 3'd2, 2'b10, 1'b0);
    expect_out(3'd0, 2'b00, 1'b0);
    rst_n = 1'b0;
    #5;
    step(1, 1, 0, 0, 0, 3'd0, 2'b00, 1'b0);
    rst_n = 1'b1;
    step(1, 1, 0, 0, 0, 3'd2, 2'b10, 1'b0);
    step(0, 0, 0, 0, 0, 3'd0, 2'b00, 1'b0);

`ifdef TURN_LANE_CHANGE_EN
    // tap: 2-cycle request still yields three full flashes
    for (int i = 0; i < 30; i++)
      step(1, i < 2, 0, 0, 0, 3'd2, {(i % 10) < 5, 1'b0}, (i % 10) == 9);
    step(1, 0, 0, 0, 0, 3'd1, 2'b00, 1'b0);
    // opposite request pre-empts the tap latch
    for (int i = 0; i < 12; i++)
      step(1, i < 2, 0, 0, 0, 3'd2, {(i % 10) < 5, 1'b0}, (i % 10) == 9);
    step(1, 0, 1, 0, 0, 3'd3, 2'b01, 1'b0);
`endif

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/turn_signal_scheduler.md
# turn_signal_scheduler

Sequences the vehicle's two indicator lamps from the driver controls (left/right stalk, hazard button, brake pedal, ignition power). Arbitrates requests by fixed priority and owns the shared blink-phase counter, so every flashing pattern is phase-aligned and restarts cleanly on a mode change. Sits between the debounced control inputs and the lamp LED pins, replacing direct per-lamp flash control.

## Interface

- PERIOD, 10_000_000: blink period in clk cycles, ≥ 2
- HALF, 5_000_000: on-phase length in cycles, 1 ≤ HALF < PERIOD
- TAP_FLASHES, 3: minimum flashes in lane-change mode, 1..15
- CNT_W, 24: phase counter width; 2^CNT_W > PERIOD
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- power  input  1  ignition on; synchronous, debounced upstream
- left_req  input  1  left stalk held
- right_req  input  1  right stalk held
- hazard_btn  input  1  hazard push-button, level; rising edge toggles hazard latch
- brake  input  1  brake pedal pressed
- led  output  2  lamp drive; led[1] left, led[0] right; registered
- state  output  3  FSM state: 0 OFF, 1 IDLE, 2 LEFT, 3 RIGHT, 4 HAZARD; registered
- flash_tick  output  1  one-cycle pulse at the end of each completed blink period in LEFT/RIGHT/HAZARD

## Operation

- Reset: state=OFF, led=00, flash_tick=0, phase counter=0, flash count=0, hazard latch=0, button-edge register=0.
- Priority, evaluated every cycle: !power → OFF; hazard latch → HAZARD; left_req&right_req → IDLE; left_req → LEFT; right_req → RIGHT; else IDLE.
- !power clears the hazard latch; hazard edges while !power are ignored.
- Phase counter runs 0..PERIOD-1 and wraps; lamp "on" phase is counter < HALF. Counter and flash count clear to 0 whenever the state changes, so the first flash after any mode entry is a full on-phase.
- Flash count (4 bits, saturating at 15) increments and flash_tick pulses when counter == PERIOD-1 in a blinking state.
- led per state: OFF 00; IDLE {brake,brake}; LEFT {on,brake}; RIGHT {brake,on}; HAZARD {on,on}. Brake is steady-on on the non-blinking side and ignored in HAZARD.
- Direct LEFT↔RIGHT switch is a state change: counter restarts.
- Counter held at 0 in OFF and IDLE.

## Timing

- Inputs sampled at each rising clk; state, led and flash_tick all update at that same edge, so latency is 1 cycle from input change to led.
- Hazard: a rising edge of hazard_btn sampled at edge k toggles the latch; state reflects it at edge k.
- In a blinking state, led is on for exactly HALF cycles and off for PERIOD-HALF cycles.
- A held hazard_btn toggles once only.
- Reset mid-blink: all outputs return to reset values asynchronously; the first edge after release evaluates priority with counter=0.

## Configuration

- TURN_LANE_CHANGE_EN defined: in LEFT/RIGHT, dropping the request with flash count < TAP_FLASHES keeps the state latched until flash_tick brings the count to TAP_FLASHES, then goes to IDLE. The opposite request, hazard, or !power pre-empts the latch immediately. Dropping the request with count ≥ TAP_FLASHES → IDLE at the next edge.
- Not defined: dropping the request → IDLE at the next edge, regardless of phase.

## Test plan

PERIOD=10, HALF=5, TAP_FLASHES=3.

- Reset, power=1, left_req=1 for 30 cycles → state=2; led[1] on for 5 cycles, off for 5, ×3; led[0]=0; flash_tick at cycles 10, 20, 30.
- Left blinking, then brake=1 → led[0]=1 steady, led[1] keeps blinking in phase; left_req=0 (macro off) → led=11 next cycle.
- Left blinking at counter=7, switch to right_req → state=3 next edge; led[0] on for a full 5 cycles from counter 0.
- hazard_btn pulse while right_req=1 → state=4, led blinks 11/00; second pulse → back to RIGHT with counter restarted; power=0 → led=00, latch cleared.
- Macro on: left_req high for 2 cycles only → exactly 3 flashes, state=1 after the third flash_tick. Repeat with right_req asserted during the 2nd flash → state=3 immediately.
- Assert rst_n=0 mid on-phase → led=00, state=0 without waiting for a clock edge.
